carryadder: RTL and testbench



---
 rtl/carryadder.sv | 121 ++++++++++++
 tb/tb_carryadder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/carryadder.sv
// carryadder: 4-bit carry-lookahead adder with registered outputs.
//
// Each carry is a flat two-level sum of products of the per-bit
// generate (g = a & b) and propagate (p = a ^ b) terms. There is no ripple
// chain between bit positions.
//
// Timing: every input is sampled on the rising edge of clk. The result
// appears on the outputs after that same edge, so the latency is one cycle.
// There is no valid/ready handshake. A new operand set is accepted on every
// cycle.
//
// Reset: rst is synchronous and active-high. It overrides the operands at
// every edge where it is asserted.
//
// Optional build macro: CARRYADDER_GROUP_PG_EN. When it is defined, the
// block gains the registered group outputs gp and gg, which feed a
// second-level lookahead unit.
module carryadder (
    input  logic clk,
    input  logic rst,
    input  logic c0,
    input  logic a0,
    input  logic b0,
    input  logic a1,
    input  logic b1,
    input  logic a2,
    input  logic b2,
    input  logic a3,
    input  logic b3,
    output logic s0,
    output logic s1,
    output logic s2,
`ifdef CARRYADDER_GROUP_PG_EN
    output logic s3,
    output logic c4,
    output logic gp,
    output logic gg
`else
    output logic s3,
    output logic c4
`endif
);

    logic g0, g1, g2, g3;
    logic p0, p1, p2, p3;
    logic c1, c2, c3, c4n;
    logic s0n, s1n, s2n, s3n;
`ifdef CARRYADDER_GROUP_PG_EN
    logic gpn, ggn;
`endif

    // Per-bit generate and propagate terms.
    always_comb begin
        g0 = a0 & b0;
        g1 = a1 & b1;
        g2 = a2 & b2;
        g3 = a3 & b3;
        p0 = a0 ^ b0;
        p1 = a1 ^ b1;
        p2 = a2 ^ b2;
        p3 = a3 ^ b3;
    end

    // Lookahead carries. Each carry is computed directly from g, p and c0
    // and never from a neighbouring carry.
    always_comb begin
        c1  = g0 | (p0 & c0);
        c2  = g1 | (p1 & g0) | (p1 & p0 & c0);
        c3  = g2 | (p2 & g1) | (p2 & p1 & g0) | (p2 & p1 & p0 & c0);
        c4n = g3 | (p3 & g2) | (p3 & p2 & g1) | (p3 & p2 & p1 & g0)
                 | (p3 & p2 & p1 & p0 & c0);
    end

    // Sum bits: the propagate term XORed with the carry into that position.
    always_comb begin
        s0n = p0 ^ c0;
        s1n = p1 ^ c1;
        s2n = p2 ^ c2;
        s3n = p3 ^ c3;
    end

`ifdef CARRYADDER_GROUP_PG_EN
    // Group propagate and generate terms. They do not depend on c0, which
    // lets an upper-level unit supply the carry into this group.
    always_comb begin
        gpn = p3 & p2 & p1 & p0;
        ggn = g3 | (p3 & g2) | (p3 & p2 & g1) | (p3 & p2 & p1 & g0);
    end
`endif

    // Output registers. Reset clears them regardless of the operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
            c4 <= 1'b0;
        end else begin
            s0 <= s0n;
            s1 <= s1n;
            s2 <= s2n;
            s3 <= s3n;
            c4 <= c4n;
        end
    end

`ifdef CARRYADDER_GROUP_PG_EN
    // Group outputs are registered with the same latency and reset as the sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            gp <= 1'b0;
            gg <= 1'b0;
        end else begin
            gp <= gpn;
            gg <= ggn;
        end
    end
`endif

endmodule

// File: tb/tb_carryadder.sv
// tb_carryadder: self-checking bench for carryadder.
// The expected values come from plain integer addition, A + B + c0, which is
// 5 bits wide. When CARRYADDER_GROUP_PG_EN is defined, the bench also checks
// the group outputs:
// - gp must equal ((A ^ B) == 15).
// - gg must equal (A + B >= 16).
module tb_carryadder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic c0 = 1'b0;
    logic a0 = 1'b0, a1 = 1'b0, a2 = 1'b0, a3 = 1'b0;
    logic b0 = 1'b0, b1 = 1'b0, b2 = 1'b0, b3 = 1'b0;
    logic s0, s1, s2, s3, c4;
`ifdef CARRYADDER_GROUP_PG_EN
    logic gp, gg;
`endif

    int checks = 0;
    int passes = 0;
    logic [4:0] exp_q[$];

    // Clock and DUT.
    always #5 clk = ~clk;

    carryadder dut (
        .clk(clk), .rst(rst), .c0(c0),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .a2(a2), .b2(b2), .a3(a3), .b3(b3),
        .s0(s0), .s1(s1), .s2(s2),
`ifdef CARRYADDER_GROUP_PG_EN
        .s3(s3), .c4(c4), .gp(gp), .gg(gg)
`else
        .s3(s3), .c4(c4)
`endif
    );

    wire [4:0] result = {c4, s3, s2, s1, s0};

    // Reference model: the registered result for one sampled input set.
    function automatic logic [4:0] model_sum(input logic [3:0] a, input logic [3:0] b,
                                             input logic c, input logic r);
        int total;
        total = int'(a) + int'(b) + int'(c);
        if (r) return 5'd0;
        return total[4:0];
    endfunction

    // Drive one input set, then return 1 time unit after the edge that samples it.
    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c, input logic r);
        {a3, a2, a1, a0} = a;
        {b3, b2, b1, b0} = b;
        c0  = c;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    // Reset dominates all-ones operands. The first edge after release adds them.
    task automatic test_reset();
        logic [4:0] exp;
        drive(4'd15, 4'd15, 1'b1, 1'b1);
        drive(4'd15, 4'd15, 1'b1, 1'b1);
        exp = model_sum(4'd15, 4'd15, 1'b1, 1'b1);
        checks++;
        if (result !== exp) $display("FAIL reset_hold: got %b want %b", result, exp);
        else passes++;
`ifdef CARRYADDER_GROUP_PG_EN
        checks++;
        if ({gp, gg} !== 2'b00) $display("FAIL reset_group: got gp=%b gg=%b want 0 0", gp, gg);
        else passes++;
`endif
        drive(4'd15, 4'd15, 1'b1, 1'b0);
        exp = model_sum(4'd15, 4'd15, 1'b1, 1'b0);
        checks++;
        if (result !== exp) $display("FAIL reset_release: got %0d want %0d", result, exp);
        else passes++;
    endtask

    // Directed corner cases: zero, full propagate chain, and generate at the MSB.
    task automatic test_directed();
        logic [3:0] ta[4] = '{4'd0, 4'd5, 4'd5, 4'd8};
        logic [3:0] tb[4] = '{4'd0, 4'd10, 4'd10, 4'd8};
        logic       tc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [4:0] want[4] = '{5'd0, 5'd16, 5'd15, 5'd16};
        for (int i = 0; i < 4; i++) begin
            drive(ta[i], tb[i], tc[i], 1'b0);
            checks++;
            if (result !== want[i] || result !== model_sum(ta[i], tb[i], tc[i], 1'b0))
                $display("FAIL directed_%0d: got %0d want %0d", i, result, want[i]);
            else passes++;
        end
`ifdef CARRYADDER_GROUP_PG_EN
        checks++;
        if ({gg, gp} !== 2'b10) $display("FAIL msb_group: got gg=%b gp=%b want 1 0", gg, gp);
        else passes++;
`endif
    endtask

    // Outputs must not change between edges, even when the inputs change.
    task automatic test_hold();
        drive(4'd3, 4'd4, 1'b0, 1'b0);
        {a3, a2, a1, a0} = 4'd15;
        {b3, b2, b1, b0} = 4'd15;
        c0 = 1'b1;
        #3;
        checks++;
        if (result !== 5'd7) $display("FAIL hold: got %0d want 7", result);
        else passes++;
    endtask

    // Exhaustive sweep of {c0, B, A}, checked every cycle through the expected queue.
    task automatic test_exhaustive();
        logic [8:0] v;
        logic [4:0] exp;
        int errs = 0;
        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            exp_q.push_back(model_sum(v[3:0], v[7:4], v[8], 1'b0));
            drive(v[3:0], v[7:4], v[8], 1'b0);
            exp = exp_q.pop_front();
            checks++;
            if (result !== exp) begin
                errs++;
                if (errs < 10)
                    $display("FAIL exhaustive A=%0d B=%0d c0=%0d: got %0d want %0d",
                             v[3:0], v[7:4], v[8], result, exp);
            end else passes++;
`ifdef CARRYADDER_GROUP_PG_EN
            checks++;
            if (c4 !== (gg | (gp & v[8])) || gp !== ((v[3:0] ^ v[7:4]) == 4'hf)
                || gg !== ((int'(v[3:0]) + int'(v[7:4])) >= 16)) begin
                errs++;
                if (errs < 10) $display("FAIL exhaustive_group i=%0d: got gp=%b gg=%b c4=%b", i, gp, gg, c4);
            end else passes++;
`endif
        end
    endtask

    // Random operands with occasional reset.
    task automatic test_random();
        logic [3:0] a, b;
        logic c, r;
        logic [4:0] exp;
        for (int i = 0; i < 300; i++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            c = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 15) == 0);
            exp_q.push_back(model_sum(a, b, c, r));
            drive(a, b, c, r);
            exp = exp_q.pop_front();
            checks++;
            if (result !== exp)
                $display("FAIL random_%0d A=%0d B=%0d c0=%0d rst=%0d: got %0d want %0d",
                         i, a, b, c, r, result, exp);
            else passes++;
        end
    endtask

    // Alternating operands every cycle, with one reset cycle in the middle.
    task automatic test_back_to_back();
        logic [3:0] a, b;
        logic r;
        logic [4:0] exp;
        for (int i = 0; i < 10; i++) begin
            a = (i % 2 == 0) ? 4'd15 : 4'd3;
            b = (i % 2 == 0) ? 4'd1 : 4'd4;
            r = (i == 5);
            exp = model_sum(a, b, 1'b0, r);
            drive(a, b, 1'b0, r);
            checks++;
            if (result !== exp)
                $display("FAIL back_to_back_%0d: got %0d want %0d", i, result, exp);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_exhaustive();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
